// File: rtl/rlc_vga_pos_out_pio_pkg.sv
// Register map and control-bit layout shared by the VGA position PIO
// and the software-facing side of the VGA port family.
package rlc_vga_pos_out_pio_pkg;

    localparam logic [1:0] ADDR_X    = 2'd0;
    localparam logic [1:0] ADDR_Y    = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_FCNT = 2'd3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_IMM    = 1;

    localparam int FCNT_W = 16;

    function automatic logic [31:0] ctrl_word(input logic imm, input logic pend);
        ctrl_word = {30'b0, imm, pend};
    endfunction

endpackage

// File: rtl/rlc_vga_pos_out_pio_if.sv
// Avalon-MM slave bus bundle for the VGA position PIO.
interface rlc_vga_pos_out_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/rlc_edge_detect.sv
// Rising-edge detector with synchronous reset; a level that is already
// high when reset releases must drop once before an edge is reported.
module rlc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_fs_d;
    logic r_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_d  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_fs_d <= i_level;
            if (!i_level) r_armed <= 1'b1;
        end
    end

    assign o_rise = i_level & ~r_fs_d & r_armed;

endmodule

// File: rtl/rlc_vga_pos_out_pio.sv
// Write-side position PIO: shadow X/Y committed to the VGA fabric at a
// frame boundary or immediately, with frame counter and pending status.
module rlc_vga_pos_out_pio
    import rlc_vga_pos_out_pio_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int RESET_X = 0,
    parameter int RESET_Y = 0
) (
    input  logic               clk,
    input  logic               reset,
    rlc_vga_pos_out_pio_if.slave bus,
    input  logic               frame_start,
    output logic [X_WIDTH-1:0] out_x,
    output logic [Y_WIDTH-1:0] out_y,
    output logic               commit_strobe
);

    localparam logic [X_WIDTH-1:0] RX = X_WIDTH'(RESET_X);
    localparam logic [Y_WIDTH-1:0] RY = Y_WIDTH'(RESET_Y);

    logic [X_WIDTH-1:0] r_sx, r_ox;
    logic [Y_WIDTH-1:0] r_sy, r_oy;
    logic               r_pend, r_imm, r_stb;
    logic [FCNT_W-1:0]  r_fcnt;
    logic [31:0]        r_rd;

    logic        w_wr, w_wx, w_wy, w_wc, w_wf;
    logic        w_edge, w_commit;
    logic [31:0] w_rd;
    logic        w_unused;

    assign w_unused = ^bus.writedata;

    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_wx     = w_wr & (bus.address == ADDR_X);
    assign w_wy     = w_wr & (bus.address == ADDR_Y);
    assign w_wc     = w_wr & (bus.address == ADDR_CTRL);
    assign w_wf     = w_wr & (bus.address == ADDR_FCNT);
    assign w_commit = w_edge & r_pend;

    rlc_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (frame_start),
        .o_rise  (w_edge)
    );

    always_comb begin
        w_rd = 32'b0;
        unique case (bus.address)
            ADDR_X:    w_rd = 32'(r_ox);
            ADDR_Y:    w_rd = 32'(r_oy);
            ADDR_CTRL: w_rd = ctrl_word(r_imm, r_pend);
            ADDR_FCNT: w_rd = 32'(r_fcnt);
            default:   w_rd = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sx   <= RX;
            r_sy   <= RY;
            r_pend <= 1'b0;
            r_imm  <= 1'b0;
            r_fcnt <= '0;
            r_rd   <= 32'b0;
        end else begin
            if (w_wx) r_sx <= bus.writedata[X_WIDTH-1:0];
            if (w_wy) r_sy <= bus.writedata[Y_WIDTH-1:0];
            if (w_wc) r_imm <= bus.writedata[CTRL_IMM];
            // a fresh request on a committing edge survives for next frame
            if (w_wc && bus.writedata[CTRL_COMMIT]) r_pend <= 1'b1;
            else if (w_commit)                      r_pend <= 1'b0;
            if (w_wf)        r_fcnt <= '0;
            else if (w_edge) r_fcnt <= r_fcnt + 1'b1;
            r_rd <= w_rd;
        end
    end

    // commit takes the pre-write shadow; an immediate write takes the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ox  <= RX;
            r_oy  <= RY;
            r_stb <= 1'b0;
        end else begin
            r_stb <= w_commit | (r_imm & (w_wx | w_wy));
            if (r_imm && w_wx) r_ox <= bus.writedata[X_WIDTH-1:0];
            else if (w_commit) r_ox <= r_sx;
            if (r_imm && w_wy) r_oy <= bus.writedata[Y_WIDTH-1:0];
            else if (w_commit) r_oy <= r_sy;
        end
    end

    assign bus.readdata  = r_rd;
    assign out_x         = r_ox;
    assign out_y         = r_oy;
    assign commit_strobe = r_stb;

endmodule

// File: tb/tb_rlc_vga_pos_out_pio.sv
// Self-checking bench for the VGA position PIO: behavioural model checked
// every cycle plus hand-computed expectations at key points.
module tb_rlc_vga_pos_out_pio;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic       commit_strobe;

    int total = 0;
    int bad = 0;
    bit mvalid = 1'b0;

    rlc_vga_pos_out_pio_if bus ();

    rlc_vga_pos_out_pio #(
        .X_WIDTH (10),
        .Y_WIDTH (9),
        .RESET_X (0),
        .RESET_Y (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .frame_start   (frame_start),
        .out_x         (out_x),
        .out_y         (out_y),
        .commit_strobe (commit_strobe)
    );

    always #5 clk = ~clk;

    logic [9:0]  m_sx, m_ox;
    logic [8:0]  m_sy, m_oy;
    logic        m_pend, m_imm, m_stb, m_prev;
    logic [15:0] m_fcnt;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Register-level reading of the behaviour, applied once per clock.
    task automatic model_step();
        logic        wr, edge_now, clr;
        logic [9:0]  nox;
        logic [8:0]  noy;
        logic [31:0] d;
        wr = bus.chipselect && !bus.write_n;
        d = bus.writedata;
        if (reset) begin
            m_sx = 0; m_ox = 0; m_sy = 0; m_oy = 0;
            m_pend = 0; m_imm = 0; m_fcnt = 0;
            m_rd = 0; m_stb = 0;
            m_prev = 1'b1;
        end else begin
            edge_now = frame_start && !m_prev;
            m_prev = frame_start;
            case (bus.address)
                2'd0: m_rd = {22'b0, m_ox};
                2'd1: m_rd = {23'b0, m_oy};
                2'd2: m_rd = {30'b0, m_imm, m_pend};
                default: m_rd = {16'b0, m_fcnt};
            endcase
            nox = m_ox; noy = m_oy; m_stb = 0; clr = 0;
            if (edge_now && m_pend) begin
                nox = m_sx; noy = m_sy; m_stb = 1; m_pend = 0;
            end
            if (wr) begin
                case (bus.address)
                    2'd0: begin
                        if (m_imm) begin nox = d[9:0]; m_stb = 1; end
                        m_sx = d[9:0];
                    end
                    2'd1: begin
                        if (m_imm) begin noy = d[8:0]; m_stb = 1; end
                        m_sy = d[8:0];
                    end
                    2'd2: begin
                        if (d[0]) m_pend = 1;
                        m_imm = d[1];
                    end
                    default: clr = 1;
                endcase
            end
            m_ox = nox; m_oy = noy;
            if (edge_now) m_fcnt = m_fcnt + 16'd1;
            if (clr) m_fcnt = 0;
        end
        mvalid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("readdata", bus.readdata, m_rd);
            chk("out_x", {22'b0, out_x}, {22'b0, m_ox});
            chk("out_y", {23'b0, out_y}, {23'b0, m_oy});
            chk("strobe", {31'b0, commit_strobe}, {31'b0, m_stb});
        end
    end

    task automatic tick(input logic r, input logic [1:0] a, input logic cs,
                        input logic wn, input logic [31:0] d, input logic f);
        @(negedge clk);
        #2;
        reset = r;
        bus.address = a;
        bus.chipselect = cs;
        bus.write_n = wn;
        bus.writedata = d;
        frame_start = f;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic f);
        tick(1'b0, a, 1'b1, 1'b0, d, f);
    endtask

    task automatic rd(input logic [1:0] a, input logic f);
        tick(1'b0, a, 1'b0, 1'b1, 32'hDEAD_BEEF, f);
    endtask

    task automatic frame();
        rd(2'd1, 1'b1);
        rd(2'd1, 1'b0);
    endtask

    initial begin
        bus.address = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = 32'b0;

        tick(1'b1, 2'd0, 1'b0, 1'b1, 32'b0, 1'b0);
        tick(1'b1, 2'd0, 1'b0, 1'b1, 32'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rd(2'(k), 1'b0);
            chk("reset_read", bus.readdata, 32'h0);
        end
        chk("reset_x", {22'b0, out_x}, 32'd0);
        chk("reset_y", {23'b0, out_y}, 32'd0);
        chk("reset_stb", {31'b0, commit_strobe}, 32'd0);

        // frame-synchronised commit; high writedata bits ignored
        wr(2'd0, 32'hFFFF_F000 | 32'd640, 1'b0);
        wr(2'd1, 32'd200, 1'b0);
        chk("no_early_x", {22'b0, out_x}, 32'd0);
        wr(2'd2, 32'h1, 1'b0);
        rd(2'd2, 1'b1);
        chk("commit_x", {22'b0, out_x}, 32'd640);
        chk("commit_y", {23'b0, out_y}, 32'd200);
        chk("commit_stb", {31'b0, commit_strobe}, 32'd1);
        rd(2'd2, 1'b0);
        chk("stb_single", {31'b0, commit_strobe}, 32'd0);
        chk("ctrl_cleared", bus.readdata, 32'h0);

        // no commit request: edges count but outputs hold
        wr(2'd3, 32'h0, 1'b0);
        wr(2'd0, 32'd100, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 32'd7, 1'b0);
        repeat (3) frame();
        rd(2'd3, 1'b0);
        chk("fcnt_3", bus.readdata, 32'd3);
        chk("x_held", {22'b0, out_x}, 32'd640);

        // immediate mode, back-to-back writes
        wr(2'd2, 32'h2, 1'b0);
        wr(2'd0, 32'd5, 1'b0);
        chk("imm_x", {22'b0, out_x}, 32'd5);
        chk("imm_stb", {31'b0, commit_strobe}, 32'd1);
        wr(2'd1, 32'd17, 1'b0);
        chk("imm_y", {23'b0, out_y}, 32'd17);
        chk("imm_stb2", {31'b0, commit_strobe}, 32'd1);
        rd(2'd2, 1'b0);
        chk("ctrl_imm", bus.readdata, 32'h2);

        // ctrl request on a committing edge stays pending
        wr(2'd2, 32'h1, 1'b0);
        wr(2'd0, 32'd77, 1'b0);
        wr(2'd2, 32'h1, 1'b1);
        chk("edge_ctrl_x", {22'b0, out_x}, 32'd77);
        rd(2'd2, 1'b0);
        chk("edge_ctrl_pend", bus.readdata, 32'h1);

        // shadow write on a committing edge commits the old shadow
        wr(2'd0, 32'd400, 1'b0);
        wr(2'd0, 32'd300, 1'b1);
        chk("edge_wr_old", {22'b0, out_x}, 32'd400);
        wr(2'd2, 32'h1, 1'b0);
        frame();
        chk("edge_wr_new", {22'b0, out_x}, 32'd300);

        // frame counter wrap
        @(negedge clk);
        force dut.r_fcnt = 16'hFFFF;
        rd(2'd0, 1'b0);
        m_fcnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_fcnt;
        rd(2'd3, 1'b0);
        chk("fcnt_ffff", bus.readdata, 32'h0000_FFFF);
        rd(2'd3, 1'b1);
        rd(2'd3, 1'b0);
        chk("fcnt_wrap", bus.readdata, 32'h0);
        wr(2'd3, 32'h0, 1'b1);
        rd(2'd3, 1'b0);
        rd(2'd3, 1'b0);
        chk("clear_wins", bus.readdata, 32'h0);

        // reset discards pending commit
        wr(2'd0, 32'd9, 1'b0);
        wr(2'd2, 32'h1, 1'b0);
        tick(1'b1, 2'd0, 1'b0, 1'b1, 32'b0, 1'b1);
        tick(1'b1, 2'd0, 1'b0, 1'b1, 32'b0, 1'b1);
        rd(2'd2, 1'b1);
        rd(2'd2, 1'b1);
        chk("rst_pend", bus.readdata, 32'h0);
        chk("rst_x", {22'b0, out_x}, 32'd0);
        rd(2'd3, 1'b0);
        rd(2'd3, 1'b0);
        chk("rst_no_edge", bus.readdata, 32'h0);
        frame();
        rd(2'd3, 1'b0);
        chk("post_rst_edge", bus.readdata, 32'h1);
        chk("post_rst_x", {22'b0, out_x}, 32'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
